// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronised rx, mid-bit sampling, single-entry output holding register.
// rxvalid rises 9.5*CLKS_PER_BIT+3 cycles after the start edge; an unacknowledged byte is overwritten (overrun pulse).
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rxack,
    output logic [7:0] rxbyte,
    output logic       rxvalid,
    output logic       overrun,
    output logic       framing_err,
    output logic       busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rxbyte_q, rxbyte_d;
    logic          rxvalid_q, rxvalid_d;
    logic          overrun_q, overrun_d;
    logic          ferr_q, ferr_d;
    logic          rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            rxbyte_q  <= '0;
            rxvalid_q <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], rx};
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            rxbyte_q  <= rxbyte_d;
            rxvalid_q <= rxvalid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        rxbyte_d  = rxbyte_q;
        rxvalid_d = rxvalid_q;
        overrun_d = 1'b0;
        ferr_d    = 1'b0;

        if (rxack && rxvalid_q) begin
            rxvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint was only a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // A load beats a coincident ack, and an ack in the same cycle rescues it from overrun.
                        rxbyte_d  = shift_q;
                        rxvalid_d = 1'b1;
                        overrun_d = rxvalid_q && !rxack;
                        state_d   = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rxbyte      = rxbyte_q;
    assign rxvalid     = rxvalid_q;
    assign overrun     = overrun_q;
    assign framing_err = ferr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1 at 16 clocks per bit: a frame-level model predicts each
// received byte / framing error, and a forked monitor pops and compares as the DUT reports them.
module tb_uart_rx_8n1;
    localparam int CPB = 16;
    localparam int FRAME = 10 * CPB;
    localparam int LAT = (19 * CPB) / 2 + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rxack;
    logic [7:0] rxbyte;
    logic       rxvalid;
    logic       overrun;
    logic       framing_err;
    logic       busy;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit done = 0;
    bit mvalid = 0;

    typedef struct {
        bit         ferr;
        logic [7:0] b;
        bit         ovr;
        int         start;
    } exp_t;
    exp_t expq[$];

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .rxack(rxack),
        .rxbyte(rxbyte),
        .rxvalid(rxvalid),
        .overrun(overrun),
        .framing_err(framing_err),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first ncyc cycles of a 10-bit frame; caller sits just after a rising edge.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int ncyc,
                              input bit push, input bit ovr);
        logic [9:0] fr;
        exp_t e;
        fr = {stop, b, 1'b0};
        if (push) begin
            e.ferr = !stop; e.b = b; e.ovr = ovr; e.start = cyc;
            expq.push_back(e);
        end
        for (int i = 0; i < ncyc; i++) begin
            rx = fr[i / CPB];
            wait_cycles(1);
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit stop);
        bit ovr;
        ovr = stop && mvalid;
        if (stop) mvalid = 1;
        send_frame(b, stop, FRAME, 1, ovr);
    endtask

    task automatic ack();
        rxack = 1;
        wait_cycles(1);
        rxack = 0;
        mvalid = 0;
        wait_cycles(2);
    endtask

    task automatic monitor();
        bit pv = 0;
        bit pa = 0;
        bit load_evt;
        int lat;
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0; pa = 0;
                continue;
            end
            load_evt = rxvalid && (!pv || pa || overrun);
            if (framing_err && overrun) begin
                chk("ferr_and_overrun", 1, 0);
            end
            if (load_evt || framing_err) begin
                if (expq.size() == 0) begin
                    chk("unexpected_event", {30'd0, framing_err, rxvalid}, 0);
                end else begin
                    e = expq.pop_front();
                    lat = cyc - e.start;
                    chk("event_kind_ferr", framing_err, e.ferr);
                    checks++;
                    if (lat < LAT - 1 || lat > LAT + 1) begin
                        failures++;
                        $display("FAIL latency: got %0d want %0d+-1", lat, LAT);
                    end
                    if (!e.ferr) begin
                        chk("rxbyte", rxbyte, e.b);
                        chk("overrun", overrun, e.ovr);
                    end
                end
            end
            pv = rxvalid;
            pa = rxack;
        end
    endtask

    task automatic stimulus();
        int g;
        bit a;
        logic [7:0] b;
        rst_n = 0; rx = 1; rxack = 0;
        wait_cycles(3);
        chk("rst_rxbyte", rxbyte, 0);
        chk("rst_rxvalid", rxvalid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_ferr", framing_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1;
        wait_cycles(5);

        // Single byte
        frame(8'h44, 1);
        wait_cycles(20);
        chk("d_rxvalid", rxvalid, 1);
        ack();
        chk("ack_clears", rxvalid, 0);

        // Back-to-back without ack: second byte overruns the first
        frame(8'h55, 1);
        frame(8'hAA, 1);
        wait_cycles(10);
        chk("ovr_rxvalid", rxvalid, 1);
        chk("ovr_rxbyte", rxbyte, 8'hAA);
        ack();

        // Ack in the exact load cycle of the second byte
        frame(8'h11, 1);
        fork
            send_frame(8'h3C, 1, FRAME, 1, 0);
            begin
                wait_cycles(LAT - 1);
                rxack = 1;
                wait_cycles(1);
                rxack = 0;
            end
        join
        mvalid = 1;
        wait_cycles(5);
        chk("ackload_rxvalid", rxvalid, 1);
        chk("ackload_rxbyte", rxbyte, 8'h3C);
        ack();

        // Start-bit glitch
        rx = 0;
        wait_cycles(5);
        rx = 1;
        wait_cycles(1);
        chk("glitch_busy_hi", busy, 1);
        wait_cycles(20);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_rxvalid", rxvalid, 0);

        // Bad stop bit followed by a long break
        frame(8'hFF, 0);
        wait_cycles(40 * CPB);
        chk("break_busy", busy, 1);
        rx = 1;
        wait_cycles(40);
        chk("break_rxvalid", rxvalid, 0);
        chk("break_idle", busy, 0);
        frame(8'h12, 1);
        wait_cycles(10);
        ack();

        // Randomised traffic with random gaps and acks
        for (int i = 0; i < 14; i++) begin
            b = 8'($urandom);
            frame(b, 1);
            g = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 30);
            a = ($urandom_range(0, 1) == 1);
            if (g > 0) begin
                if (a) ack();
                wait_cycles(g);
            end
        end
        wait_cycles(10);
        ack();

        // Reset during data bit 4
        send_frame(8'h5A, 1, 5 * CPB + CPB / 2, 0, 0);
        rst_n = 0;
        rx = 1;
        wait_cycles(1);
        chk("midrst_busy", busy, 0);
        chk("midrst_rxbyte", rxbyte, 0);
        chk("midrst_rxvalid", rxvalid, 0);
        wait_cycles(3);
        rst_n = 1;
        wait_cycles(10);
        chk("postrst_busy", busy, 0);
        frame(8'h81, 1);
        wait_cycles(10);
        chk("post_rst_rxbyte", rxbyte, 8'h81);
        wait_cycles(50);
        done = 1;
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join
        chk("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
